// File: rtl/count_arb.sv
// count_arb: round-robin arbiter that lets one of two requesters stream a
// burst of LEN serial bits into a shared sequence detector. The arbiter
// counts the detector's hits during the burst and reports the total.
//
// All flops update on the falling edge of ck. rst_n is asynchronous and
// active-low.
//
// Ports
//   ck          clock (falling-edge active)
//   rst_n       asynchronous active-low reset
//   req0/req1   burst requests
//   a0/a1       requester serial data bits
//   gnt0/gnt1   one-hot grant, high during FLUSH, STREAM and DONE
//   a           serial bit to the detector (0 outside STREAM)
//   clr         one-cycle flush pulse to the detector (FLUSH state)
//   b           detector hit flag
//   done        burst-complete pulse (DONE state)
//   abort       one-cycle pulse after the granted requester drops req
//   hcnt        hit count of the last completed burst
//   state_o     current FSM state, for observation
//
// Handshake: a requester raises req and keeps it high for the whole burst.
// gnt tells it that it owns the datapath. If req drops while gnt is high
// and before DONE, the burst is abandoned. The requester that is not
// granted is ignored until the FSM is back in IDLE.
module count_arb #(
  parameter int LEN = 8
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       a0,
  input  logic       a1,
  input  logic       b,
  output logic       gnt0,
  output logic       gnt1,
  output logic       a,
  output logic       clr,
  output logic       done,
  output logic       abort,
  output logic [3:0] hcnt,
  output logic [1:0] state_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] LAST = 4'(LEN - 1);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;   // granted requester: 0 or 1
  logic       prio_q, prio_d;     // requester that wins a tie
  logic [3:0] cnt_q, cnt_d;       // STREAM cycles completed
  logic [3:0] acc_q, acc_d;       // hits seen in the current burst
  logic [3:0] hcnt_q, hcnt_d;
  logic       abort_q, abort_d;

  logic       req_own;
  logic [3:0] acc_inc;

  always_comb begin
    req_own = owner_q ? req1 : req0;
    // Saturating add of this cycle's hit.
    acc_inc = (acc_q == 4'd15) ? acc_q : acc_q + {3'd0, b};

    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hcnt_d  = hcnt_q;
    abort_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the pointer decides. A lone requester always wins.
          owner_d = (req0 && req1) ? prio_q : req1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = 4'd0;
        acc_d = 4'd0;
        if (!req_own) begin
          state_d = IDLE;
          abort_d = 1'b1;
          prio_d  = ~prio_q;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!req_own) begin
          state_d = IDLE;
          abort_d = 1'b1;
          prio_d  = ~prio_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
          acc_d = acc_inc;
          if (cnt_q == LAST) begin
            // Load hcnt with the final hit so it is valid while done is high.
            state_d = DONE;
            hcnt_d  = acc_inc;
          end
        end
      end
      default: begin // DONE
        state_d = IDLE;
        prio_d  = ~prio_q;
      end
    endcase
  end

  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= 4'd0;
      acc_q   <= 4'd0;
      hcnt_q  <= 4'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hcnt_q  <= hcnt_d;
      abort_q <= abort_d;
    end
  end

  // Outputs are decoded from the registered state. A reset therefore clears
  // them at once, without waiting for a clock edge.
  assign gnt0    = (state_q != IDLE) && !owner_q;
  assign gnt1    = (state_q != IDLE) &&  owner_q;
  assign a       = (state_q == STREAM) && (owner_q ? a1 : a0);
  assign clr     = (state_q == FLUSH);
  assign done    = (state_q == DONE);
  assign abort   = abort_q;
  assign hcnt    = hcnt_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_count_arb.sv
// Directed bench for count_arb. One instance uses LEN=8 and a second uses
// LEN=15. Inputs change and outputs are sampled just after the rising edge
// of ck, which keeps them away from the active falling edge.
module tb_count_arb;

  logic       ck = 1'b1;
  logic       rst_n;
  logic       req0, req1, a0, a1, b;
  logic       gnt0, gnt1, a, clr, done, abort;
  logic [3:0] hcnt;
  logic [1:0] state_o;

  logic       s_req0, s_req1, s_a0, s_a1, s_b;
  logic       s_gnt0, s_gnt1, s_a, s_clr, s_done, s_abort;
  logic [3:0] s_hcnt;
  logic [1:0] s_state_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock. Falling edges occur at 5, 15, 25 and so on.
  always #5 ck = ~ck;

  count_arb #(.LEN(8)) u_dut (
    .ck(ck), .rst_n(rst_n), .req0(req0), .req1(req1), .a0(a0), .a1(a1),
    .b(b), .gnt0(gnt0), .gnt1(gnt1), .a(a), .clr(clr), .done(done),
    .abort(abort), .hcnt(hcnt), .state_o(state_o)
  );

  count_arb #(.LEN(15)) u_sat (
    .ck(ck), .rst_n(rst_n), .req0(s_req0), .req1(s_req1), .a0(s_a0),
    .a1(s_a1), .b(s_b), .gnt0(s_gnt0), .gnt1(s_gnt1), .a(s_a), .clr(s_clr),
    .done(s_done), .abort(s_abort), .hcnt(s_hcnt), .state_o(s_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one cycle. This passes one falling edge and stops just after
  // the following rising edge.
  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  // Run one LEN=8 burst on u_dut. The caller must have just observed IDLE
  // and must already hold the request(s) high.
  task automatic burst8(input logic owner, input logic [7:0] ap0,
                        input logic [7:0] ap1, input logic [7:0] bp,
                        input logic [3:0] hexp);
    tick;
    check("flush_gnt", {gnt0, gnt1}, {~owner, owner});
    check("flush_clr_a", {clr, a, done}, 3'b100);
    for (int i = 0; i < 8; i++) begin
      tick;
      a0 = ap0[i];
      a1 = ap1[i];
      b  = bp[i];
      #1;
      check("stream_a", a, owner ? ap1[i] : ap0[i]);
      check("stream_gnt_clr", {gnt0, gnt1, clr, done}, {~owner, owner, 2'b00});
    end
    tick;
    b = 1'b0;
    check("done_pulse", {done, gnt0, gnt1, a}, {1'b1, ~owner, owner, 1'b0});
    check("done_hcnt", hcnt, hexp);
  endtask

  initial begin
    rst_n = 1'b0;
    {req0, req1, a0, a1, b} = '0;
    {s_req0, s_req1, s_a0, s_a1, s_b} = '0;

    // Reset state.
    tick;
    tick;
    check("rst_outs", {gnt0, gnt1, a, clr, done, abort}, 6'b0);
    check("rst_hcnt", hcnt, 4'd0);
    check("rst_state", state_o, 2'd0);
    rst_n = 1'b1;

    // Contention from reset: requester 0 is served first, then requester 1.
    req0 = 1'b1;
    req1 = 1'b1;
    burst8(1'b0, 8'hA5, 8'h3C, 8'b0000_0101, 4'd2);
    tick;
    check("cont_idle_gap", {gnt0, gnt1}, 2'b00);
    check("cont_hcnt_hold", hcnt, 4'd2);
    burst8(1'b1, 8'h0F, 8'hC3, 8'hFF, 4'd8);
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    check("cont_release", {gnt0, gnt1, done}, 3'b000);

    // Single requester. Hits land on stream cycles 4..8, so hcnt must be 5.
    req0 = 1'b1;
    burst8(1'b0, 8'hFF, 8'h00, 8'b1111_1000, 4'd5);
    req0 = 1'b0;
    tick;
    check("single_release", {gnt0, done}, 2'b00);
    check("single_hcnt_hold", hcnt, 4'd5);

    // Abort: requester 1 drops req on its 3rd STREAM cycle.
    req1 = 1'b1;
    a1   = 1'b1;
    b    = 1'b1;
    tick;
    check("ab_flush", {gnt0, gnt1, clr}, 3'b011);
    tick;
    tick;
    tick;
    check("ab_stream3", {gnt1, a}, 2'b11);
    req1 = 1'b0;
    tick;
    check("ab_pulse", {abort, done, gnt0, gnt1, a}, 5'b10000);
    check("ab_hcnt", hcnt, 4'd5);
    tick;
    check("ab_one_cycle", abort, 1'b0);
    // After the abort the pointer must favour requester 0.
    req0 = 1'b1;
    req1 = 1'b1;
    tick;
    check("ab_prio", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    req1 = 1'b0;
    b    = 1'b0;
    a1   = 1'b0;
    tick;
    check("flush_abort", {abort, gnt0, done}, 3'b100);
    tick;

    // Reset mid-STREAM for half a period.
    req0 = 1'b1;
    a0   = 1'b1;
    tick;
    tick;
    tick;
    check("mid_stream", {gnt0, a}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {gnt0, gnt1, a, clr, done, abort}, 6'b0);
    check("mid_rst_hcnt", hcnt, 4'd0);
    #4;
    rst_n = 1'b1;
    tick;
    check("post_rst_idle", {state_o, done, abort}, 4'b0000);
    burst8(1'b0, 8'h5A, 8'h00, 8'h00, 4'd0);
    req0 = 1'b0;
    tick;

    // Idle with every data input high: nothing may move.
    a0 = 1'b1;
    a1 = 1'b1;
    b  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      check("idle_quiet", {gnt0, gnt1, a, clr, done, abort}, 6'b0);
    end
    a0 = 1'b0;
    a1 = 1'b0;
    b  = 1'b0;

    // LEN=15 burst with b held high: hcnt must reach 15 and not wrap.
    s_req0 = 1'b1;
    s_a0   = 1'b1;
    s_b    = 1'b1;
    tick;
    check("sat_flush", {s_gnt0, s_clr}, 2'b11);
    for (int i = 0; i < 15; i++) begin
      tick;
      check("sat_stream", {s_gnt0, s_a, s_done, s_clr}, 4'b1100);
    end
    tick;
    check("sat_done", s_done, 1'b1);
    check("sat_hcnt", s_hcnt, 4'd15);
    s_req0 = 1'b0;
    s_b    = 1'b0;
    tick;
    check("sat_hold", {s_gnt0, s_done, s_hcnt}, 6'b00_1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_arb.md
COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 SHALL have parameter LEN, default 8, meaning the number of bits streamed per granted burst (legal range 1..15).
REQ-002 SHALL have port ck  input  1  clock; all flops update on the falling edge of ck.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1 each  requester burst requests.
REQ-005 SHALL have ports a0, a1  input  1 each  requester serial data bits.
REQ-006 SHALL have ports gnt0, gnt1  output  1 each  one-hot grant.
REQ-007 SHALL have port a  output  1  serial bit driven to the shared sequence-detector datapath.
REQ-008 SHALL have port clr  output  1  one-cycle flush pulse to the datapath.
REQ-009 SHALL have port b  input  1  detector hit flag returned by the datapath.
REQ-010 SHALL have ports done  output  1  burst-complete pulse; abort  output  1  burst-aborted pulse.
REQ-011 SHALL have port hcnt  output  4  hit count of the last completed burst.

Function
REQ-012 SHALL implement FSM states IDLE, FLUSH, STREAM, DONE.
REQ-013 IDLE: if any req is high, SHALL grant one requester and enter FLUSH; otherwise stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: a one-bit priority pointer, 0 after reset, selects the requester that wins when both request; a lone requester always wins.
REQ-015 FLUSH: SHALL last exactly one cycle, assert clr=1, drive a=0, clear the bit counter and the hit accumulator, then enter STREAM.
REQ-016 STREAM: SHALL drive a with the granted requester's bit (a0 or a1) combinationally, for exactly LEN cycles.
REQ-017 STREAM: SHALL increment the hit accumulator on each cycle in which b=1, sampled on the same edge that advances the bit counter.
REQ-018 The hit accumulator SHALL saturate at 15.
REQ-019 After the LEN-th STREAM cycle, SHALL enter DONE.
REQ-020 DONE: SHALL last one cycle with done=1, load hcnt from the accumulator, and toggle the priority pointer to the other requester.
REQ-021 DONE: SHALL release the grant and return to IDLE.
REQ-022 hcnt SHALL hold its value until the next DONE.
REQ-023 If the granted requester drops req during FLUSH or STREAM, SHALL assert abort for one cycle and return to IDLE.
REQ-024 On abort: no done, hcnt unchanged, and the priority pointer toggles.
REQ-025 The non-granted requester's req and data SHALL be ignored until the FSM returns to IDLE.
REQ-026 gnt0/gnt1 SHALL be high exactly during FLUSH, STREAM and DONE for the owning requester; never both high.
REQ-027 Outside STREAM, a SHALL be 0.
REQ-028 A requester holding req high through DONE SHALL be re-arbitrated in IDLE and not granted back-to-back while the other requests.

Reset
REQ-029 On rst_n=0, SHALL immediately force state=IDLE, priority=0, gnt0=gnt1=0, a=0, clr=0, done=0, abort=0, hcnt=0, and clear the bit counter and hit accumulator, regardless of the ck phase.
REQ-030 Reset asserted mid-burst SHALL discard the burst without a done or abort pulse.
REQ-031 After rst_n rises, the first falling edge of ck SHALL evaluate IDLE.

Verification
REQ-032 Single requester: req0=1, a0=1 for 8 cycles, model b=1 on cycles 4..8 -> gnt0 for 10 cycles, clr in cycle 1, done in cycle 10, hcnt=5.
REQ-033 Contention: req0=req1=1 from reset -> requester 0 served first, then requester 1; gnt0 and gnt1 never overlap; requester 0 not re-granted while req1 is high.
REQ-034 Abort: req1 dropped on the 3rd STREAM cycle -> one abort pulse, no done, hcnt keeps its prior value, priority points to requester 0.
REQ-035 Saturation: LEN=15, b held at 1 -> hcnt=15 after done, no wrap to 0.
REQ-036 Reset mid-STREAM: rst_n low for half a ck period -> all outputs go to 0 asynchronously; the next burst starts from FLUSH with clr=1.
REQ-037 Idle: no req for 20 cycles -> gnt0=gnt1=0, a=0, and no done, abort or clr pulses.
